// File: rtl/sg_pkg.sv
// Shared types and defaults for the Savitzky-Golay sample path.
// SG_EDGE_PAD_EN (define) turns on mirror edge padding in sg_sample_streamer.
package sg_pkg;
    localparam int SG_DATA_W   = 8;
    localparam int SG_DEPTH    = 1024;
    localparam int SG_HALF_WIN = 3;

    typedef logic [SG_DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } state_t;
endpackage

// File: rtl/sg_sample_ram.sv
// Sample buffer: one write port and one synchronous read port. Contents are never reset.
module sg_sample_ram
    import sg_pkg::*;
#(
    parameter int DATA_W = SG_DATA_W,
    parameter int DEPTH  = SG_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/sg_sample_streamer.sv
// Replays a buffered sample block over valid/ready with first/last markers.
// Define SG_EDGE_PAD_EN to emit HALF_WIN mirrored samples at each block edge.
module sg_sample_streamer
    import sg_pkg::*;
#(
    parameter int DATA_W   = SG_DATA_W,
    parameter int DEPTH    = SG_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int HALF_WIN = SG_HALF_WIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last
);
`ifdef SG_EDGE_PAD_EN
    localparam int PAD_EN = 1;
`else
    localparam int PAD_EN = 0;
`endif
    localparam int PAD   = HALF_WIN * PAD_EN;
    localparam int CNT_W = ADDR_W + 2;
    localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W+1)'(PAD + 1);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t state;
    logic [CNT_W-1:0]  n_beats, rd_idx, n_acc, n_cur, idx_p0;
    logic              len_ok, accept, pop;
    logic              rd_en_p0, first_p0, last_p0;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic              vld_p1, first_p1, last_p1;
    logic [DATA_W-1:0] rd_data_p1;
    logic [DATA_W+1:0] in_p1, head_p2, tail_p2;
    logic [1:0]        cnt_p2;
    logic [2:0]        occ_nxt;

    assign len_ok  = (len >= LEN_MIN) && (len <= LEN_MAX);
    assign accept  = (state == IDLE) && start && len_ok;
    assign n_acc   = CNT_W'(len) + CNT_W'(2 * PAD);
    assign pop     = (cnt_p2 != 2'd0) && m_ready;
    // Skid occupancy after this edge; a read may only be issued if its data will find a free slot.
    assign occ_nxt = {1'b0, cnt_p2} + {2'b00, vld_p1} - {2'b00, pop};

    // p0: read issue; sample 0 is fetched on the accepting edge so PRIME already holds it
    always_comb begin
        idx_p0   = accept ? '0 : rd_idx;
        n_cur    = accept ? n_acc : n_beats;
        rd_en_p0 = accept || (((state == PRIME) || (state == STREAM)) &&
                              (rd_idx < n_beats) && (occ_nxt <= 3'd1));
        first_p0 = (idx_p0 == '0);
        last_p0  = (idx_p0 == n_cur - CNT_W'(1));
    end

`ifdef SG_EDGE_PAD_EN
    logic [ADDR_W:0] len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        len_q <= '0;
        else if (accept) len_q <= len;
    end

    function automatic logic [ADDR_W-1:0] mirror_addr(input logic [CNT_W-1:0] p,
                                                      input logic [ADDR_W:0]  n);
        logic signed [CNT_W+1:0] src, top;
        src = $signed({2'b00, p}) - (CNT_W+2)'(PAD);
        top = $signed({{(CNT_W+1-ADDR_W){1'b0}}, n}) - (CNT_W+2)'(1);
        if (src[CNT_W+1])  src = -src;
        else if (src > top) src = top + top - src;
        return src[ADDR_W-1:0];
    endfunction

    assign rd_addr_p0 = mirror_addr(idx_p0, accept ? len : len_q);
`else
    assign rd_addr_p0 = idx_p0[ADDR_W-1:0];
`endif

    sg_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en_p0),
        .rd_addr (rd_addr_p0),
        .rd_data (rd_data_p1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_len <= 1'b0;
            n_beats <= '0;
            rd_idx  <= '0;
        end else begin
            done    <= 1'b0;
            err_len <= 1'b0;
            if (rd_en_p0) rd_idx <= idx_p0 + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state   <= PRIME;
                            busy    <= 1'b1;
                            n_beats <= n_acc;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                PRIME:  state <= STREAM;
                STREAM: begin
                    if (pop && head_p2[DATA_W]) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1: RAM output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p1 <= 1'b0;
        else      vld_p1 <= rd_en_p0;
    end

    always_ff @(posedge clk) begin
        first_p1 <= first_p0;
        last_p1  <= last_p0;
    end

    assign in_p1 = {first_p1, last_p1, rd_data_p1};

    // p2: two-entry skid, head drives the outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p2  <= 2'd0;
            head_p2 <= '0;
        end else begin
            case ({vld_p1, pop})
                2'b10: begin
                    if (cnt_p2 == 2'd0) head_p2 <= in_p1;
                    cnt_p2 <= cnt_p2 + 2'd1;
                end
                2'b01: begin
                    head_p2 <= tail_p2;
                    cnt_p2  <= cnt_p2 - 2'd1;
                end
                2'b11:   head_p2 <= (cnt_p2 == 2'd1) ? in_p1 : tail_p2;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1 && (((cnt_p2 == 2'd1) && !pop) || ((cnt_p2 == 2'd2) && pop)))
            tail_p2 <= in_p1;
    end

    assign m_valid = (cnt_p2 != 2'd0);
    assign m_data  = head_p2[DATA_W-1:0];
    assign m_last  = head_p2[DATA_W];
    assign m_first = head_p2[DATA_W+1];
endmodule

// File: tb/tb_sg_sample_streamer.sv
// Scoreboard bench for sg_sample_streamer: stimulus queues expected beats, a monitor checks them.
module tb_sg_sample_streamer;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic          clk, rst, wr_en, start, m_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   len;
    logic          busy, done, err_len, m_valid, m_first, m_last;
    logic [DW-1:0] m_data;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] tb_mem [DEPTH];
    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0, beat_cnt = 0, last_beat_cyc = -100;
    bit            tog = 0;

    sg_sample_streamer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .busy(busy), .done(done), .err_len(err_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_first(m_first), .m_last(m_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (tog) m_ready = ~m_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_addr(input int p, input int n);
        int s;
        s = p;
`ifdef SG_EDGE_PAD_EN
        s = p - 3;
        if (s < 0) s = -s;
        else if (s >= n) s = 2 * (n - 1) - s;
`endif
        return s;
    endfunction

    function automatic int n_beats(input int n);
`ifdef SG_EDGE_PAD_EN
        return n + 6;
`else
        return n;
`endif
    endfunction

    // monitor: pops an expected beat on every handshake, checks stall stability
    initial begin
        bit     prev_stall = 0;
        beat_t  prev_b, e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_hold", {m_data, m_first, m_last}, prev_b);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", m_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e.d);
                        check("beat_first", m_first, e.f);
                        check("beat_last", m_last, e.l);
                    end
                    beat_cnt++;
                    if (m_last) last_beat_cyc = cyc;
                end
                prev_stall = m_valid && !m_ready;
                prev_b = {m_data, m_first, m_last};
            end
        end
    end

    task automatic do_write(input int a, input int d, input bit track);
        wr_en = 1; wr_addr = AW'(a); wr_data = DW'(d);
        @(posedge clk); #1;
        wr_en = 0;
        if (track) tb_mem[a] = DW'(d);
    endtask

    task automatic push_block(input int n);
        beat_t b;
        int    nb;
        nb = n_beats(n);
        for (int p = 0; p < nb; p++) begin
            b.d = tb_mem[exp_addr(p, n)];
            b.f = (p == 0);
            b.l = (p == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_block(input int n);
        len = (AW+1)'(n); start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1);
        if (seen) begin
            check({name, "_done_after_last"}, cyc, last_beat_cyc + 1);
            check({name, "_busy_in_done"}, busy, 1);
            check({name, "_valid_in_done"}, m_valid, 0);
            check({name, "_queue_empty"}, exp_q.size(), 0);
            @(negedge clk);
            check({name, "_busy_fall"}, busy, 0);
            check({name, "_done_pulse"}, done, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] pad_exp [16] = '{40, 30, 20, 10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 90, 80, 70};
        beat_t b;
        int    base;
        rst = 0; wr_en = 0; start = 0; len = '0; wr_addr = '0; wr_data = '0; m_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_len", err_len, 0);
        check("rst_valid", m_valid, 0);
        check("rst_first", m_first, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) do_write(i, i, 1);

        // 1: full-rate stream, latency
        push_block(10);
        start_block(10);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_valid_c1", m_valid, 0);
        @(negedge clk);
        check("t1_valid_c2", m_valid, 1);
        wait_done("t1");

        // 2: m_ready toggling
        push_block(10);
        tog = 1;
        start_block(10);
        wait_done("t2");
        tog = 0; m_ready = 1;

        // 3: illegal lengths
        start_block(0);
        @(negedge clk);
        check("t3_err_len0", err_len, 1);
        check("t3_busy0", busy, 0);
        @(posedge clk); #1;
        start_block(DEPTH + 1);
        @(negedge clk);
        check("t3_err_lenbig", err_len, 1);
        check("t3_busybig", busy, 0);
        repeat (3) @(negedge clk);
        check("t3_no_valid", m_valid, 0);
        check("t3_err_clear", err_len, 0);
        @(posedge clk); #1;

        // 4: reset mid-stream
        push_block(10);
        base = beat_cnt;
        start_block(10);
        for (int i = 0; i < 100 && beat_cnt < base + 4; i++) @(posedge clk);
        check("t4_four_beats", beat_cnt >= base + 4, 1);
        #2 rst = 0;
        #1;
        check("t4_valid_async", m_valid, 0);
        check("t4_busy_async", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        push_block(10);
        start_block(10);
        wait_done("t4");

        // 6: start and write during STREAM are ignored
        push_block(10);
        start_block(10);
        @(posedge clk); #1;
        wr_en = 1; wr_addr = '0; wr_data = 8'd99; start = 1; len = 11'd5;
        @(posedge clk); #1;
        wr_en = 0; start = 0;
        @(negedge clk);
        check("t6_no_err", err_len, 0);
        wait_done("t6a");
        push_block(10);
        b = exp_q[0];
        check("t6_replay_beat0_exp", b.d, tb_mem[exp_addr(0, 10)]);
        start_block(10);
        wait_done("t6b");

`ifdef SG_EDGE_PAD_EN
        // 5: mirror padding
        for (int i = 0; i < 10; i++) do_write(i, 10 * (i + 1), 1);
        for (int p = 0; p < 16; p++) begin
            b.d = pad_exp[p];
            b.f = (p == 0);
            b.l = (p == 15);
            exp_q.push_back(b);
        end
        start_block(10);
        wait_done("t5");
        start_block(3);
        @(negedge clk);
        check("t5_err_len3", err_len, 1);
        check("t5_busy3", busy, 0);
        @(posedge clk); #1;
`else
        pad_exp[0] = pad_exp[0];
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
